// File: rtl/wb_demux10.sv
// wb_demux10: ten-way writeback demultiplexer with a one-entry holding register.
// A word plus a 4-bit destination code (0..9) is captured and presented on exactly one
// channel's valid until that channel's ready is seen. Codes 10..15 are dropped and counted.
module wb_demux10 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_pulse,
    output logic [7:0]       err_count
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    localparam logic [3:0] MaxLegalSel = 4'd9;
    localparam logic [7:0] ErrCountMax = 8'd255;

    state_e           state_q, state_d;
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] data_q;
    logic             err_pulse_q;
    logic [7:0]       err_count_q;

    logic             hold_valid;
    logic [NCH-1:0]   sel_onehot;
    logic             drain;
    logic             acc;
    logic             sel_legal;
    logic             legal_acc;
    logic             illegal_acc;

    assign hold_valid = (state_q == StFull);
    assign sel_legal  = (in_sel <= MaxLegalSel);

    // Decode the held destination; non-selected out_ready bits are masked out.
    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_q == 4'(k)) begin
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // Handshake terms; in_ready is independent of in_valid.
    always_comb begin
        drain       = hold_valid & |(sel_onehot & out_ready);
        in_ready    = ~hold_valid | drain;
        acc         = in_valid & in_ready;
        legal_acc   = acc & sel_legal;
        illegal_acc = acc & ~sel_legal;
    end

    // Next-state: illegal words never change the state on their own.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (legal_acc) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (drain && !legal_acc) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding register: loads on legal accept, otherwise keeps the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            data_q <= '0;
        end else if (legal_acc) begin
            sel_q  <= in_sel;
            data_q <= in_data;
        end
    end

    // Error pulse follows each illegal accept by one cycle; counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= illegal_acc;
            if (illegal_acc && (err_count_q != ErrCountMax)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Output drive.
    always_comb begin
        out_valid = hold_valid ? sel_onehot : '0;
        out_data  = data_q;
        err_pulse = err_pulse_q;
        err_count = err_count_q;
    end

endmodule

// File: doc/wb_demux10.md
# wb_demux10

Ten-way output demultiplexer with a one-entry holding register and per-channel valid/ready handshakes. It is the counterpart of the 10:1 select mux: it takes one data word plus a 4-bit destination code (same encoding, 0..9) and delivers the word to exactly one of ten destinations. It sits on the processor writeback path, fanning a single result bus out to ten consumer ports (register/latch banks, I/O stubs). Codes 10..15 are illegal; words carrying them are dropped and counted.

## Interface
- WIDTH, default 8: data word width in bits.
- NCH, default 10: number of output channels; fixed at 10, and the sel decode is defined for 10 only.

- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid, input, 1: upstream word present.
- in_ready, output, 1: block can accept a word this cycle.
- in_sel, input, 4: destination code; 0..9 legal.
- in_data, input, WIDTH: word to route.
- out_valid, output, NCH: one-hot (or zero) channel valid; bit k means channel k.
- out_ready, input, NCH: per-channel consumer ready.
- out_data, output, WIDTH: held word, shared by all channels; meaningful only where out_valid is set.
- err_pulse, output, 1: single-cycle pulse, one cycle after an illegal word is accepted.
- err_count, output, 8: number of illegal words dropped; saturates at 255.

## Operation
- State: hold_valid (1 bit), sel_q (4 bits), data_q (WIDTH bits), err_pulse register, err_count register.
- FSM states: EMPTY (hold_valid=0) and FULL (hold_valid=1).
- Accept condition: acc = in_valid & in_ready.
- Drain condition: drain = hold_valid & out_ready[sel_q].
- in_ready = !hold_valid | drain. It is combinational from out_ready and never depends on in_valid.
- out_valid[k] = hold_valid & (sel_q == k). At most one bit is ever set.
- out_data = data_q.
- On acc with in_sel <= 9:
  - Load sel_q and data_q.
  - Set hold_valid=1.
- On acc with in_sel >= 10:
  - Do not load. hold_valid becomes !drain if FULL, otherwise stays 0.
  - Set err_pulse=1 next cycle and increment err_count unless it is at 255.
- On drain without a legal acc: hold_valid=0, and data_q/sel_q keep their values.
- Simultaneous drain and legal acc: the new word replaces the held word in the same edge and hold_valid stays 1. This gives full throughput, one word per cycle.
- Transitions:
  - EMPTY→FULL on legal acc.
  - FULL→EMPTY on drain with no legal acc.
  - FULL→FULL on no drain, or on drain plus legal acc.
  - Illegal acc never changes the state by itself.
- out_ready bits of non-selected channels are ignored.

## Timing
- Reset values: hold_valid=0, out_valid=0, in_ready=1, sel_q=0, data_q=0, out_data=0, err_pulse=0, err_count=0.
- rst has priority over every other input. If rst is asserted while FULL, the held word is discarded and no channel sees it.
- Latency: a word accepted at edge N appears on out_valid/out_data from cycle N+1. It stays stable until the edge at which out_ready[sel_q] is sampled high.
- Out-valid rule: once asserted, out_valid[k] and out_data do not change until drain, so consumers may stall indefinitely.
- In-ready rule: in_ready may fall only while FULL and the selected out_ready is low.
- err_pulse is high for exactly one cycle per illegal acc. Back-to-back illegal words keep it high on consecutive cycles.
- Saturation: err_count increments by 1 per illegal acc and holds at 255 once reached.

## Test plan
- Reset then idle: assert rst for 2 cycles with in_valid=1 → all outputs zero and in_ready=1; out_valid stays 0 after rst falls while in_valid=0.
- Sweep all legal codes: for sel=0..9, send data=0xA0+sel with out_ready all 1 → out_valid one-hot at bit sel, one cycle later, with out_data=0xA0+sel; 10 words in 10 cycles, in_ready constantly 1.
- Backpressure: send sel=3, data=0x5C with out_ready[3]=0 for 5 cycles and out_ready of all other channels =1 → out_valid=0x008 and out_data=0x5C stable; in_ready=0; raising out_ready[3] drains the word and in_ready=1 in that same cycle.
- Illegal codes: send sel=10..15 → nothing on out_valid, six single-cycle err_pulse highs, err_count=6; then 300 illegal words → err_count=255.
- Simultaneous drain and accept: while holding sel=7 with out_ready[7]=1, present sel=2, data=0x11 → next cycle out_valid=0x004, out_data=0x11, no bubble.
- Reset mid-operation: while FULL on sel=9, assert rst → next cycle hold_valid=0, out_valid=0, err_count=0, and the word is never delivered.
